// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOT  = 4'd5,
      ALU_PASS = 4'd6,
      ALU_ADC  = 4'd7,
      ALU_SHL  = 4'd8,
      ALU_SHR  = 4'd9,
      ALU_SAR  = 4'd10,
      ALU_MUL  = 4'd11
   } op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DONE
   } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, done after SIZE steps.
module alu_mul_iter #(
   parameter int SIZE = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic            done,
   output logic [SIZE-1:0] prod_lo,
   output logic            prod_hi_nz
);

   localparam int CW = $clog2(SIZE + 1);

   logic [2*SIZE-1:0] mcand_q, mcand_d;
   logic [2*SIZE-1:0] acc_q, acc_d;
   logic [SIZE-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, busy_d;

   always_comb begin
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done     = busy_q && (cnt_q == CW'(SIZE));
      if (start) begin
         mcand_d  = {{SIZE{1'b0}}, a};
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (done) begin
         busy_d = 1'b0;
      end else if (busy_q) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CW'(1);
      end
   end

   assign prod_lo    = acc_q[SIZE-1:0];
   assign prod_hi_nz = |acc_q[2*SIZE-1:SIZE];

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes, committed flags register and
// an optional iterative multiplier.
module alu_mc
   import alu_pkg::*;
#(
   parameter int SIZE   = 16,
   parameter int MUL_EN = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic [3:0]      op,
   input  logic            flag_write,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] result,
   output logic [3:0]      alu_flags,
   output logic [3:0]      flags_reg
);

   localparam logic [SIZE-1:0] SIZE_V = SIZE[SIZE-1:0];

   state_e          state_q, state_d;
   logic [SIZE-1:0] result_q, result_d;
   logic [3:0]      flags_q, flags_d;
   logic [3:0]      flags_reg_q, flags_reg_d;
   logic            fw_q, fw_d;

   op_e             op_in;
   logic            legal, is_mul, accept, out_hs, commit, carry_in;
   logic [SIZE-1:0] addend, comb_res;
   logic            add_cin, comb_c, comb_v, big;
   logic [SIZE:0]   sum, shl_ext, shr_ext, sar_ext;
   logic [3:0]      comb_flags;
   logic            mul_start, mul_done, mul_hi_nz;
   logic [SIZE-1:0] mul_lo;

   // Single-cycle datapath, evaluated on the live inputs so it lands in the
   // result register on the accepting edge. ADC takes the carry being
   // committed on this same edge when there is one.
   always_comb begin
      op_in    = op_e'(op);
      legal    = (op <= 4'd10) || ((op == 4'd11) && (MUL_EN != 0));
      is_mul   = legal && (op_in == ALU_MUL);
      carry_in = commit ? flags_q[FLAG_C] : flags_reg_q[FLAG_C];
      addend   = (op_in == ALU_SUB) ? ~b : b;
      add_cin  = (op_in == ALU_SUB) ? 1'b1 : ((op_in == ALU_ADC) ? carry_in : 1'b0);
      sum      = {1'b0, a} + {1'b0, addend} + {{SIZE{1'b0}}, add_cin};
      big      = (b >= SIZE_V);
      shl_ext  = {1'b0, a} << b;
      shr_ext  = {a, 1'b0} >> b;
      sar_ext  = $signed({a, 1'b0}) >>> b;
      comb_res = '0;
      comb_c   = 1'b0;
      comb_v   = 1'b0;
      case (op_in)
         ALU_ADD, ALU_SUB, ALU_ADC: begin
            comb_res = sum[SIZE-1:0];
            comb_c   = sum[SIZE];
            comb_v   = (a[SIZE-1] == addend[SIZE-1]) && (sum[SIZE-1] != a[SIZE-1]);
         end
         ALU_AND:  comb_res = a & b;
         ALU_OR:   comb_res = a | b;
         ALU_XOR:  comb_res = a ^ b;
         ALU_NOT:  comb_res = ~a;
         ALU_PASS: comb_res = b;
         ALU_SHL: begin
            comb_res = big ? '0 : shl_ext[SIZE-1:0];
            comb_c   = big ? 1'b0 : shl_ext[SIZE];
         end
         ALU_SHR: begin
            comb_res = big ? '0 : shr_ext[SIZE:1];
            comb_c   = big ? 1'b0 : shr_ext[0];
         end
         ALU_SAR: begin
            comb_res = big ? {SIZE{a[SIZE-1]}} : sar_ext[SIZE:1];
            comb_c   = big ? a[SIZE-1] : sar_ext[0];
         end
         default: comb_res = '0;
      endcase
      if (legal && !is_mul) begin
         comb_flags = {comb_res[SIZE-1], (comb_res == '0), comb_c, comb_v};
      end else begin
         comb_flags = '0;
         comb_res   = '0;
      end
   end

   // Handshake control and next-state logic.
   always_comb begin
      in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
      out_valid   = (state_q == DONE);
      accept      = in_valid && in_ready;
      out_hs      = out_valid && out_ready;
      commit      = out_hs && fw_q;
      mul_start   = accept && is_mul;
      state_d     = state_q;
      result_d    = result_q;
      flags_d     = flags_q;
      fw_d        = fw_q;
      flags_reg_d = commit ? flags_q : flags_reg_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               fw_d = flag_write && legal;
               if (is_mul) begin
                  state_d = MUL;
               end else begin
                  state_d  = DONE;
                  result_d = comb_res;
                  flags_d  = comb_flags;
               end
            end else if (out_hs) begin
               state_d = IDLE;
            end
         end
         MUL: begin
            if (mul_done) begin
               state_d  = DONE;
               result_d = mul_lo;
               flags_d  = {mul_lo[SIZE-1], (mul_lo == '0), mul_hi_nz, mul_hi_nz};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   generate
      if (MUL_EN != 0) begin : g_mul
         alu_mul_iter #(.SIZE(SIZE)) u_mul (
            .clk        (clk),
            .reset      (reset),
            .start      (mul_start),
            .a          (a),
            .b          (b),
            .done       (mul_done),
            .prod_lo    (mul_lo),
            .prod_hi_nz (mul_hi_nz)
         );
      end else begin : g_no_mul
         assign mul_done  = 1'b0;
         assign mul_lo    = '0;
         assign mul_hi_nz = 1'b0;
      end
   endgenerate

   assign result    = result_q;
   assign alu_flags = flags_q;
   assign flags_reg = flags_reg_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         result_q    <= '0;
         flags_q     <= '0;
         flags_reg_q <= '0;
         fw_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         flags_reg_q <= flags_reg_d;
         fw_q        <= fw_d;
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (SIZE=16): scoreboard of modelled results
// plus per-scenario inline checks on handshake timing and flags_reg.
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic [3:0]  op;
   logic        flag_write;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [3:0]  alu_flags;
   logic [3:0]  flags_reg;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  flags;
   } exp_t;

   exp_t       sb_q[$];
   logic [3:0] model_fr = 4'h0;
   int         checks = 0;
   int         passes = 0;

   always #5 clk = ~clk;

   alu_mc #(.SIZE(16), .MUL_EN(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .op         (op),
      .flag_write (flag_write),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .alu_flags  (alu_flags),
      .flags_reg  (flags_reg)
   );

   // Reference model: returns {flags, result}.
   function automatic logic [19:0] model(input logic [3:0] mop, input logic [15:0] ma,
                                         input logic [15:0] mb, input logic cin);
      logic [15:0] r;
      logic        c, v, ok;
      logic [31:0] p;
      int          sa, sbv, si, amt;
      r = 16'h0; c = 1'b0; v = 1'b0; ok = 1'b1; p = 32'h0; si = 0;
      sa  = $signed(ma);
      sbv = $signed(mb);
      amt = int'(mb);
      case (mop)
         4'd0: begin p = 32'(ma) + 32'(mb); si = sa + sbv; end
         4'd1: begin p = 32'(ma) + 32'(16'(~mb)) + 32'd1; si = sa - sbv; end
         4'd7: begin p = 32'(ma) + 32'(mb) + 32'(cin); si = sa + sbv + int'(cin); end
         default: ;
      endcase
      case (mop)
         4'd0, 4'd1, 4'd7: begin
            r = p[15:0]; c = p[16]; v = (si > 32767) || (si < -32768);
         end
         4'd2: r = ma & mb;
         4'd3: r = ma | mb;
         4'd4: r = ma ^ mb;
         4'd5: r = ~ma;
         4'd6: r = mb;
         4'd8: begin
            r = ma;
            if (amt >= 16) r = 16'h0;
            else for (int i = 0; i < amt; i++) begin c = r[15]; r = {r[14:0], 1'b0}; end
         end
         4'd9: begin
            r = ma;
            if (amt >= 16) r = 16'h0;
            else for (int i = 0; i < amt; i++) begin c = r[0]; r = {1'b0, r[15:1]}; end
         end
         4'd10: begin
            r = ma;
            if (amt >= 16) begin r = {16{ma[15]}}; c = ma[15]; end
            else for (int i = 0; i < amt; i++) begin c = r[0]; r = {r[15], r[15:1]}; end
         end
         4'd11: begin
            p = 32'(ma) * 32'(mb); r = p[15:0]; c = (p[31:16] != 16'h0); v = c;
         end
         default: ok = 1'b0;
      endcase
      if (!ok) return 20'h0;
      return {r[15], (r == 16'h0), c, v, r};
   endfunction

   task automatic push_expected(input logic [3:0] mop, input logic [15:0] ma,
                                input logic [15:0] mb, input logic mfw);
      logic [19:0] m;
      exp_t        e;
      m = model(mop, ma, mb, model_fr[1]);
      e.res   = m[15:0];
      e.flags = m[19:16];
      sb_q.push_back(e);
      if (mfw && (mop < 4'd12)) model_fr = m[19:16];
   endtask

   // Offer one op and return #1 after the edge that accepts it.
   task automatic send(input logic [3:0] sop, input logic [15:0] sa,
                       input logic [15:0] sb, input logic sfw);
      int waited = 0;
      in_valid = 1'b1; op = sop; a = sa; b = sb; flag_write = sfw;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         checks++;
         $display("[TB] FAIL accept_timeout: in_ready=%0b required 1 (op=%0d)", in_ready, sop);
         in_valid = 1'b0;
      end else begin
         push_expected(sop, sa, sb, sfw);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(output bit ok);
      int n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      ok = (sb_q.size() == 0);
   endtask

   // Scoreboard: compare every output handshake against the head of the queue.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         checks++;
         if (sb_q.size() == 0) begin
            $display("[TB] FAIL unexpected_output: result=%h flags=%b, no result required", result, alu_flags);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (result !== e.res || alu_flags !== e.flags)
               $display("[TB] FAIL sb_result: got %h/%b required %h/%b", result, alu_flags, e.res, e.flags);
            else
               passes++;
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = 16'h0; b = 16'h0; op = 4'h0; flag_write = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++; if (out_valid !== 1'b0) $display("[TB] FAIL rst_out_valid: got %b required 0", out_valid); else passes++;
      checks++; if (result !== 16'h0) $display("[TB] FAIL rst_result: got %h required 0000", result); else passes++;
      checks++; if (alu_flags !== 4'h0) $display("[TB] FAIL rst_alu_flags: got %b required 0000", alu_flags); else passes++;
      checks++; if (flags_reg !== 4'h0) $display("[TB] FAIL rst_flags_reg: got %b required 0000", flags_reg); else passes++;
      checks++; if (in_ready !== 1'b1) $display("[TB] FAIL rst_in_ready: got %b required 1", in_ready); else passes++;
   endtask

   task automatic test_add();
      out_ready = 1'b1;
      send(4'd0, 16'h7FFF, 16'h0001, 1'b1);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) $display("[TB] FAIL add_latency: out_valid=%b required 1", out_valid); else passes++;
      @(posedge clk);
      #1;
      checks++; if (flags_reg !== 4'b1001) $display("[TB] FAIL add_flags_reg: got %b required 1001", flags_reg); else passes++;
      checks++; if (out_valid !== 1'b0) $display("[TB] FAIL add_single_hs: out_valid=%b required 0", out_valid); else passes++;
   endtask

   task automatic test_single_ops();
      bit ok;
      logic [3:0] rop;
      out_ready = 1'b1;
      send(4'd1,  16'h0005, 16'h0005, 1'b0);
      send(4'd9,  16'h0001, 16'h0001, 1'b0);
      send(4'd10, 16'h8000, 16'h0004, 1'b0);
      send(4'd8,  16'h8001, 16'd16,   1'b0);
      send(4'd10, 16'h8000, 16'd20,   1'b0);
      send(4'd8,  16'h8001, 16'd0,    1'b0);
      send(4'd9,  16'h8001, 16'd15,   1'b0);
      for (int i = 0; i < 24; i++) begin
         rop = 4'($urandom_range(0, 10));
         if (rop >= 4'd8)
            send(rop, 16'($urandom), 16'($urandom_range(0, 18)), 1'($urandom));
         else
            send(rop, 16'($urandom), 16'($urandom), 1'($urandom));
      end
      in_valid = 1'b0;
      drain(ok);
      checks++; if (!ok) $display("[TB] FAIL ops_drain: %0d results outstanding, required 0", sb_q.size()); else passes++;
      checks++; if (flags_reg !== model_fr) $display("[TB] FAIL ops_flags_reg: got %b required %b", flags_reg, model_fr); else passes++;
   endtask

   task automatic test_adc_forward();
      bit ok;
      out_ready = 1'b1;
      send(4'd2, 16'h0000, 16'h0000, 1'b1);
      send(4'd0, 16'hFFFF, 16'h0001, 1'b1);
      send(4'd7, 16'h0000, 16'h0000, 1'b0);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h0001)
         $display("[TB] FAIL adc_forward: valid=%b result=%h required 1/0001", out_valid, result);
      else passes++;
      drain(ok);
      checks++; if (!ok) $display("[TB] FAIL adc_drain: %0d outstanding, required 0", sb_q.size()); else passes++;
      checks++; if (flags_reg !== 4'b0110) $display("[TB] FAIL adc_flags_reg: got %b required 0110", flags_reg); else passes++;
   endtask

   task automatic test_mul();
      bit ok;
      int cycles = 0;
      int busy_bad = 0;
      out_ready = 1'b1;
      send(4'd11, 16'h0100, 16'h0100, 1'b0);
      in_valid = 1'b0;
      while (cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
         if (out_valid) break;
         if (in_ready !== 1'b0) busy_bad++;
      end
      checks++; if (cycles != 17) $display("[TB] FAIL mul_latency: %0d cycles required 17", cycles); else passes++;
      checks++; if (busy_bad != 0) $display("[TB] FAIL mul_in_ready: high in %0d MUL cycles, required 0", busy_bad); else passes++;
      for (int i = 0; i < 4; i++)
         send(4'd11, 16'($urandom), 16'($urandom), 1'($urandom));
      send(4'd11, 16'h00FF, 16'h0101, 1'b1);
      in_valid = 1'b0;
      drain(ok);
      checks++; if (!ok) $display("[TB] FAIL mul_drain: %0d outstanding, required 0", sb_q.size()); else passes++;
      checks++; if (flags_reg !== model_fr) $display("[TB] FAIL mul_flags_reg: got %b required %b", flags_reg, model_fr); else passes++;
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      send(4'd4, 16'hF0F0, 16'h0FF0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         op = 4'($urandom_range(0, 10)); a = 16'($urandom); b = 16'($urandom);
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         checks++;
         if (result !== 16'hFF00 || alu_flags !== 4'b1000 || out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("[TB] FAIL stall_hold: res=%h flags=%b ov=%b ir=%b required ff00/1000/1/0",
                     result, alu_flags, out_valid, in_ready);
         else passes++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) $display("[TB] FAIL stall_single_hs: out_valid=%b required 0", out_valid); else passes++;
      checks++; if (sb_q.size() != 0) $display("[TB] FAIL stall_sb: %0d outstanding, required 0", sb_q.size()); else passes++;
   endtask

   task automatic test_reset_mid_mul();
      bit ok;
      int seen = 0;
      out_ready = 1'b1;
      send(4'd0, 16'h7FFF, 16'h0001, 1'b1);
      in_valid = 1'b0;
      drain(ok);
      checks++; if (!ok || flags_reg !== 4'b1001) $display("[TB] FAIL pre_reset_flags: got %b required 1001", flags_reg); else passes++;
      send(4'd11, 16'h0003, 16'h0005, 1'b1);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      void'(sb_q.pop_back());
      model_fr = 4'h0;
      checks++;
      if (out_valid !== 1'b0 || flags_reg !== 4'h0 || in_ready !== 1'b1)
         $display("[TB] FAIL mid_mul_reset: ov=%b fr=%b ir=%b required 0/0000/1", out_valid, flags_reg, in_ready);
      else passes++;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      checks++; if (seen != 0) $display("[TB] FAIL aborted_mul_output: out_valid seen %0d cycles, required 0", seen); else passes++;
   endtask

   task automatic test_illegal();
      bit ok;
      out_ready = 1'b1;
      send(4'd0, 16'h7FFF, 16'h0001, 1'b1);
      send(4'hC, 16'h1234, 16'h5678, 1'b1);
      send(4'hF, 16'hFFFF, 16'hFFFF, 1'b1);
      in_valid = 1'b0;
      drain(ok);
      checks++; if (!ok) $display("[TB] FAIL illegal_drain: %0d outstanding, required 0", sb_q.size()); else passes++;
      checks++; if (flags_reg !== 4'b1001) $display("[TB] FAIL illegal_flags_reg: got %b required 1001", flags_reg); else passes++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_single_ops();
      test_adc_forward();
      test_mul();
      test_stall();
      test_reset_mid_mul();
      test_illegal();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU. Successor to the combinational 16-bit ALU.
- Adds a valid/ready handshake on input and output, a registered flags register (FlagWrite), add-with-carry, shifts, and an iterative multiply.
- Sits between the register-file read stage and writeback in the CPU datapath. Tolerates writeback stalls.

Parameters:
- SIZE, 16: operand/result width, ≥4.
- MUL_EN, 1: 1 implements MUL; 0 makes MUL an illegal op.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready at a rising edge
- a  in  SIZE  operand A
- b  in  SIZE  operand B (shift amount for shifts)
- op  in  4  operation code
- flag_write  in  1  commit this op's flags to flags_reg
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes the result
- result  out  SIZE  registered result
- alu_flags  out  4  {N,Z,C,V} of result
- flags_reg  out  4  committed {N,Z,C,V}

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: state IDLE, out_valid=0, result=0, alu_flags=0, flags_reg=0, in_ready=1 in the cycle after reset. Reset mid-MUL aborts the op; no output is produced.
- Op codes:
  - 0 ADD, 1 SUB (a+~b+1), 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 PASS b
  - 7 ADC (a+b+flags_reg.C)
  - 8 SHL, 9 SHR logical, 10 SAR
  - 11 MUL (low SIZE bits of a*b)
  - 12-15 illegal
- Illegal op: result=0, alu_flags=0, flags_reg never updated.
- Flags:
  - N = result[SIZE-1]; Z = (result==0).
  - ADD/SUB/ADC: C = adder carry-out (SUB: 1 = no borrow); V = signed overflow.
  - Logic/NOT/PASS: C=0, V=0.
  - Shifts: C = last bit shifted out, 0 if amount=0; V=0.
  - MUL: C=V=(upper SIZE bits of the full product != 0).
- Shifts: amount = b as unsigned.
  - Amount ≥ SIZE: SHL/SHR give 0, SAR gives all-sign.
  - C for amount ≥ SIZE: SHL/SHR → 0; SAR → sign bit.
- FSM states:
  - IDLE: accept op → single-cycle ops go to DONE; MUL goes to MUL.
  - MUL: iterative shift-add, one bit per cycle, SIZE cycles → DONE.
  - DONE: out_valid=1; hold until out_ready.
    - out_ready && in_valid → accept the next op in the same edge.
    - out_ready alone → IDLE.
- Latency and throughput:
  - Single-cycle ops: out_valid in the cycle after acceptance; back-to-back throughput 1/cycle when out_ready=1.
  - MUL: out_valid exactly SIZE+1 cycles after acceptance.
- in_ready = (state==IDLE) || (state==DONE && out_ready). in_ready is low throughout MUL.
- Stall: while out_valid && !out_ready, result, alu_flags and out_valid hold stable.
- Operand capture: a, b, op and flag_write are captured at acceptance. Input changes afterwards are ignored.
- flags_reg commit: updates to alu_flags at the output handshake edge when the captured flag_write=1.
- ADC carry forwarding: if the accepting edge coincides with a committing output handshake, ADC uses that committed C, not the stale flags_reg.C.

Decomposition:
- alu_pkg:
  - op_e enum (ALU_ADD … ALU_MUL)
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - state_e {IDLE, MUL, DONE}
- Sub-module alu_mul_iter: shift-add multiplier.
  - Ports: start, a, b → done, prod_lo, prod_hi_nz.
  - Parametrised by SIZE; instantiated only when MUL_EN=1.

Test Plan (SIZE=16):
- ADD 0x7FFF+0x0001, flag_write=1, out_ready=1 → result 0x8000, alu_flags 4'b1001, flags_reg=1001 after handshake, out_valid one cycle after acceptance.
- SUB 0x0005-0x0005 → result 0x0000, alu_flags 4'b0110. SHR 0x0001 by 1 → 0x0000, flags 0110. SAR 0x8000 by 4 → 0xF800, flags 1000.
- ADD 0xFFFF+0x0001 with flag_write=1, followed back-to-back by ADC 0x0000+0x0000 accepted on the same edge as the first handshake → ADC result 0x0001 (forwarded carry).
- MUL 0x0100*0x0100 → result 0x0000, alu_flags 4'b0111. out_valid exactly 17 cycles after acceptance; in_ready=0 during MUL.
- out_ready held low 3 cycles after XOR 0xF0F0^0x0FF0 → result 0xFF00 stable, out_valid=1, in_ready=0. Changing a/b/op during the stall has no effect. out_ready=1 → single handshake.
- reset asserted at cycle 5 of a MUL → next cycle out_valid=0, flags_reg=0, in_ready=1. Op 4'hC → result 0, flags 0, flags_reg unchanged.
